// File: rtl/vx_queue_scheduler_pkg.sv
// ============================================================================
// Module : vx_queue_scheduler_pkg
// Brief  : Shared lane-index type and round-robin search helper.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package vx_queue_scheduler_pkg;

  localparam int MAX_REQS  = 32;
  localparam int LANE_IDXW = 5;

  typedef logic [LANE_IDXW-1:0] lane_idx_t;

  // First set bit of mask[0 +: n], scanning from start and wrapping at n.
  function automatic lane_idx_t rr_first(input logic [MAX_REQS-1:0] mask,
                                         input lane_idx_t            start,
                                         input int                   n);
    lane_idx_t res;
    logic      found;
    int        idx;
    res   = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQS; k++) begin
      idx = int'(start) + k;
      if (idx >= n) idx = idx - n;
      if ((k < n) && !found && mask[idx[LANE_IDXW-1:0]]) begin
        res   = idx[LANE_IDXW-1:0];
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vx_queue_scheduler_fifo.sv
// ============================================================================
// Module : vx_queue_scheduler_fifo
// Brief  : Per-lane FIFO, unregistered head, no bypass paths.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module vx_queue_scheduler_fifo #(
  parameter int DATAW = 32,
  parameter int DEPTH = 4,
  parameter int SIZEW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [DATAW-1:0] data_in,
  output logic [DATAW-1:0] data_out,
  output logic             empty,
  output logic             full,
  output logic [SIZEW-1:0] size
);

  localparam int ADDRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATAW-1:0] r_mem [DEPTH];
  logic [ADDRW-1:0] r_wr_ptr;
  logic [ADDRW-1:0] r_rd_ptr;
  logic [SIZEW-1:0] r_size;

  assign empty    = (r_size == '0);
  assign full     = (r_size == SIZEW'(DEPTH));
  assign size     = r_size;
  assign data_out = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_size   <= '0;
    end else begin
      if (push) r_wr_ptr <= (r_wr_ptr == ADDRW'(DEPTH - 1)) ? '0 : r_wr_ptr + ADDRW'(1);
      if (pop)  r_rd_ptr <= (r_rd_ptr == ADDRW'(DEPTH - 1)) ? '0 : r_rd_ptr + ADDRW'(1);
      case ({push, pop})
        2'b10:   r_size <= r_size + SIZEW'(1);
        2'b01:   r_size <= r_size - SIZEW'(1);
        default: r_size <= r_size;
      endcase
    end
  end

  a_no_pop_empty:  assert property (@(posedge clk) disable iff (reset) pop  |-> !empty);
  a_no_push_full:  assert property (@(posedge clk) disable iff (reset) push |-> !full);

endmodule

`default_nettype wire

// File: rtl/vx_queue_scheduler.sv
// ============================================================================
// Module : vx_queue_scheduler
// Brief  : Round-robin scheduler merging NUM_REQS FIFO-decoupled lanes.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module vx_queue_scheduler
  import vx_queue_scheduler_pkg::*;
#(
  parameter int NUM_REQS   = 4,
  parameter int DATAW      = 32,
  parameter int QUEUE_SIZE = 4,
  parameter int REQ_SELW   = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
  parameter int SIZEW      = $clog2(QUEUE_SIZE + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       valid_in,
  input  logic [NUM_REQS*DATAW-1:0] data_in,
  output logic [NUM_REQS-1:0]       ready_in,
  output logic                      valid_out,
  output logic [DATAW-1:0]          data_out,
  output logic [REQ_SELW-1:0]       sel_out,
  input  logic                      ready_out,
  output logic [NUM_REQS*SIZEW-1:0] occupancy,
  output logic                      busy
);

  logic [NUM_REQS-1:0] w_push;
  logic [NUM_REQS-1:0] w_pop;
  logic [NUM_REQS-1:0] w_empty;
  logic [NUM_REQS-1:0] w_full;
  logic [NUM_REQS-1:0] w_nonempty;
  logic [DATAW-1:0]    w_head [NUM_REQS];
  logic [REQ_SELW-1:0] w_winner;
  logic                w_load;

  logic                r_valid;
  logic [DATAW-1:0]    r_data;
  logic [REQ_SELW-1:0] r_sel;
  logic [REQ_SELW-1:0] r_rr_ptr;

  assign ready_in   = ~w_full;
  assign w_push     = valid_in & ready_in;
  assign w_nonempty = ~w_empty;
  assign w_load     = (~r_valid | ready_out) & (|w_nonempty);
  assign w_winner   = REQ_SELW'(rr_first(MAX_REQS'(w_nonempty), lane_idx_t'(r_rr_ptr), NUM_REQS));

  for (genvar i = 0; i < NUM_REQS; i++) begin : g_lane
    assign w_pop[i] = w_load && (w_winner == REQ_SELW'(i));

    vx_queue_scheduler_fifo #(
      .DATAW (DATAW),
      .DEPTH (QUEUE_SIZE),
      .SIZEW (SIZEW)
    ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (w_push[i]),
      .pop      (w_pop[i]),
      .data_in  (data_in[i*DATAW +: DATAW]),
      .data_out (w_head[i]),
      .empty    (w_empty[i]),
      .full     (w_full[i]),
      .size     (occupancy[i*SIZEW +: SIZEW])
    );
  end

  // Pointer wraps explicitly so non-power-of-2 lane counts rotate correctly.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_sel    <= '0;
      r_rr_ptr <= '0;
    end else if (w_load) begin
      r_valid  <= 1'b1;
      r_data   <= w_head[w_winner];
      r_sel    <= w_winner;
      r_rr_ptr <= (w_winner == REQ_SELW'(NUM_REQS - 1)) ? '0 : w_winner + REQ_SELW'(1);
    end else if (ready_out) begin
      r_valid  <= 1'b0;
    end
  end

  assign valid_out = r_valid;
  assign data_out  = r_data;
  assign sel_out   = r_sel;
  assign busy      = (|w_nonempty) | r_valid;

  a_sel_range: assert property (@(posedge clk) disable iff (reset)
    valid_out |-> (int'(sel_out) < NUM_REQS));
  a_stall_stable: assert property (@(posedge clk) disable iff (reset)
    (valid_out && !ready_out) |=> ($stable(data_out) && $stable(sel_out)));

endmodule

`default_nettype wire

// File: tb/tb_vx_queue_scheduler.sv
// ============================================================================
// Module : tb_vx_queue_scheduler
// Brief  : Randomized and directed checks against a queue-based lane model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_vx_queue_scheduler;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   valid_in;
  logic [127:0] data_in;
  logic [3:0]   ready_in;
  logic         valid_out;
  logic [31:0]  data_out;
  logic [1:0]   sel_out;
  logic         ready_out;
  logic [11:0]  occupancy;
  logic         busy;

  logic [2:0]   valid_in3;
  logic [95:0]  data_in3;
  logic [2:0]   ready_in3;
  logic         valid_out3;
  logic [31:0]  data_out3;
  logic [1:0]   sel_out3;
  logic         ready_out3;
  logic [8:0]   occupancy3;
  logic         busy3;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  vx_queue_scheduler #(.NUM_REQS(4), .DATAW(32), .QUEUE_SIZE(4)) u_dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
    .ready_in(ready_in), .valid_out(valid_out), .data_out(data_out),
    .sel_out(sel_out), .ready_out(ready_out), .occupancy(occupancy), .busy(busy)
  );

  vx_queue_scheduler #(.NUM_REQS(3), .DATAW(32), .QUEUE_SIZE(4)) u_dut3 (
    .clk(clk), .reset(reset), .valid_in(valid_in3), .data_in(data_in3),
    .ready_in(ready_in3), .valid_out(valid_out3), .data_out(data_out3),
    .sel_out(sel_out3), .ready_out(ready_out3), .occupancy(occupancy3), .busy(busy3)
  );

  // Reference model: one queue per lane plus an output slot and a rotating start lane.
  logic [31:0] mq [4][$];
  logic        m_vo;
  logic [31:0] m_data;
  int          m_sel;
  int          m_rr;

  function automatic logic [51:0] exp_vec();
    logic [3:0]  rdy;
    logic [11:0] occ;
    logic        any;
    any = m_vo;
    for (int i = 0; i < 4; i++) begin
      rdy[i]         = (mq[i].size() < 4);
      occ[i*3 +: 3]  = 3'(mq[i].size());
      if (mq[i].size() > 0) any = 1'b1;
    end
    return {m_vo, m_data, 2'(m_sel), rdy, occ, any};
  endfunction

  function automatic logic [51:0] dut_vec();
    return {valid_out, data_out, sel_out, ready_in, occupancy, busy};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) mq[i].delete();
    m_vo = 1'b0; m_data = '0; m_sel = 0; m_rr = 0;
  endtask

  task automatic model_step(input logic [3:0] vin, input logic [127:0] din, input logic rdy);
    logic [3:0] acc;
    bit         any;
    int         w;
    any = 0;
    for (int i = 0; i < 4; i++) begin
      acc[i] = vin[i] && (mq[i].size() < 4);
      if (mq[i].size() > 0) any = 1;
    end
    if ((!m_vo || rdy) && any) begin
      w = -1;
      for (int k = 0; k < 4; k++)
        if (w < 0 && mq[(m_rr + k) % 4].size() > 0) w = (m_rr + k) % 4;
      m_data = mq[w].pop_front();
      m_sel  = w;
      m_vo   = 1'b1;
      m_rr   = (w + 1) % 4;
    end else if (rdy) begin
      m_vo = 1'b0;
    end
    for (int i = 0; i < 4; i++)
      if (acc[i]) mq[i].push_back(din[i*32 +: 32]);
  endtask

  task automatic drive(input logic [3:0] vin, input logic [127:0] din, input logic rdy);
    valid_in  = vin;
    data_in   = din;
    ready_out = rdy;
    @(posedge clk);
    model_step(vin, din, rdy);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; valid_in = '0; data_in = '0; ready_out = 1'b0;
    valid_in3 = '0; data_in3 = '0; ready_out3 = 1'b0;
    @(posedge clk);
    model_clear();
    #1;
    reset = 1'b0;
  endtask

  function automatic logic [127:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({valid_out, data_out, sel_out, ready_in, occupancy, busy} !== {1'b0, 32'h0, 2'd0, 4'hF, 12'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset: got %h want %h", dut_vec(), {1'b0, 32'h0, 2'd0, 4'hF, 12'h0, 1'b0});
    end
  endtask

  task automatic test_wrap3();
    logic [34:0] exp3 [4];
    exp3[0] = {1'b1, 2'd1, 32'hB1};
    exp3[1] = {1'b1, 2'd2, 32'hC2};
    exp3[2] = {1'b1, 2'd0, 32'hA0};
    exp3[3] = {1'b0, 2'd0, 32'hA0};
    do_reset();
    ready_out3 = 1'b1;
    valid_in3  = 3'b010; data_in3 = {32'h0, 32'hB1, 32'h0};
    @(posedge clk); #1;
    valid_in3  = 3'b101; data_in3 = {32'hC2, 32'h0, 32'hA0};
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      valid_in3 = '0;
      vectors++;
      if ({valid_out3, sel_out3, data_out3} !== exp3[k]) begin
        miscompares++;
        $display("FAIL wrap3 step %0d: got %h want %h", k, {valid_out3, sel_out3, data_out3}, exp3[k]);
      end
    end
    vectors++;
    if (busy3 !== 1'b0 || occupancy3 !== 9'h0) begin
      miscompares++;
      $display("FAIL wrap3 idle: busy %b occ %h want 0 0", busy3, occupancy3);
    end
  endtask

  task automatic test_single();
    logic [127:0] d;
    do_reset();
    d = '0; d[31:0] = 32'hA;
    drive(4'b0001, d, 1'b1);
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL single cyc %0d: got %h want %h", k, dut_vec(), exp_vec());
      end
      if (k == 1) begin
        vectors++;
        if ({valid_out, data_out, sel_out} !== {1'b1, 32'hA, 2'd0}) begin
          miscompares++;
          $display("FAIL single out: got %h want %h", {valid_out, data_out, sel_out}, {1'b1, 32'hA, 2'd0});
        end
      end
      drive(4'b0000, '0, 1'b1);
    end
  endtask

  task automatic test_round_robin();
    logic [127:0] d;
    logic [34:0]  want;
    do_reset();
    for (int j = 0; j < 2; j++) begin
      for (int i = 0; i < 4; i++) d[i*32 +: 32] = 32'(16 * i + j);
      drive(4'hF, d, 1'b0);
    end
    for (int k = 0; k < 9; k++) begin
      want = (k < 8) ? {1'b1, 2'(k % 4), 32'(16 * (k % 4) + k / 4)} : {1'b0, 2'd3, 32'h31};
      vectors++;
      if ({valid_out, sel_out, data_out} !== want || dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL rr grant %0d: got %h want %h", k, {valid_out, sel_out, data_out}, want);
      end
      drive(4'h0, '0, 1'b1);
    end
  endtask

  task automatic test_full();
    logic [127:0] d;
    do_reset();
    for (int n = 0; n < 5; n++) begin
      d = '0; d[64 +: 32] = 32'h200 + 32'(n);
      drive(4'b0100, d, 1'b0);
    end
    vectors++;
    if (ready_in[2] !== 1'b0 || occupancy[8:6] !== 3'd4) begin
      miscompares++;
      $display("FAIL full: ready %b occ %0d want 0 4", ready_in[2], occupancy[8:6]);
    end
    d[64 +: 32] = 32'h2EE;
    drive(4'b0100, d, 1'b0);
    vectors++;
    if (occupancy[8:6] !== 3'd4 || dut_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL full ignore: got %h want %h", dut_vec(), exp_vec());
    end
    d[64 +: 32] = 32'h2FF;
    drive(4'b0100, d, 1'b1);
    vectors++;
    if (occupancy[8:6] !== 3'd3 || ready_in[2] !== 1'b1) begin
      miscompares++;
      $display("FAIL full no-bypass: occ %0d ready %b want 3 1", occupancy[8:6], ready_in[2]);
    end
    for (int k = 0; k < 6; k++) begin
      drive(4'h0, '0, 1'b1);
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL full drain %0d: got %h want %h", k, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] held_d;
    logic [1:0]  held_s;
    do_reset();
    drive(4'hF, rand_data(), 1'b0);
    drive(4'hF, rand_data(), 1'b0);
    held_d = m_data;
    held_s = 2'(m_sel);
    for (int k = 0; k < 5; k++) begin
      drive(4'hF, rand_data(), 1'b0);
      vectors++;
      if ({valid_out, data_out, sel_out} !== {1'b1, held_d, held_s} || dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL stall %0d: got %h want %h", k, dut_vec(), exp_vec());
      end
    end
    for (int k = 0; k < 18; k++) begin
      drive(4'h0, '0, 1'b1);
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL stall drain %0d: got %h want %h", k, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(4'b0111, rand_data(), 1'b0);
    drive(4'b0111, rand_data(), 1'b0);
    do_reset();
    vectors++;
    if ({valid_out, busy, occupancy, ready_in} !== {1'b0, 1'b0, 12'h0, 4'hF} || dut_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL reset mid: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      drive(4'($urandom), rand_data(), ($urandom_range(0, 3) != 0));
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL random cyc %0d: got %h want %h", k, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    reset = 1'b1; valid_in = '0; data_in = '0; ready_out = 1'b0;
    valid_in3 = '0; data_in3 = '0; ready_out3 = 1'b0;
    test_reset();
    test_wrap3();
    test_single();
    test_round_robin();
    test_full();
    test_stall();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
